// File: rtl/dcm_prog_ctrl.sv
// dcm_prog_ctrl: shares the DCM programming port between requesters A and B.
// Round-robin grant, strobe for PULSE_CYCLES, settle for SETTLE_CYCLES, then
// verify the DCM readback before acknowledging the grantee.
// Optional feature macro: DCM_PROG_CTRL_RETRY_EN (one retry on readback mismatch).
module dcm_prog_ctrl #(
   parameter int PULSE_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_a,
   input  logic [2:0] code_a,
   input  logic       req_b,
   input  logic [2:0] code_b,
   input  logic       clr_err,
   input  logic [2:0] prog_rb,
   output logic [2:0] prog_code,
   output logic       update_clock,
   output logic       ack_a,
   output logic       ack_b,
   output logic       ack_err,
   output logic       busy,
   output logic       err
);

   // One shared counter covers both the strobe and the settle window.
   localparam int MAX_CYCLES = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PULSE,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             grant_b_reg, grant_b_next;   // grantee of current transaction, 1 = B
   logic             rr_b_reg, rr_b_next;         // side favoured on a tie, 1 = B
   logic [2:0]       prog_code_reg, prog_code_next;
   logic             update_clock_reg, update_clock_next;
   logic             ack_a_reg, ack_a_next;
   logic             ack_b_reg, ack_b_next;
   logic             ack_err_reg, ack_err_next;
   logic             busy_reg, busy_next;
   logic             err_reg, err_next;
   logic             err_set;
`ifdef DCM_PROG_CTRL_RETRY_EN
   logic             retry_reg, retry_next;       // a retry has already been spent
`endif

   // Arbitration: a lone request wins, a tie goes to the round-robin side.
   logic       grant_sel;
   logic [2:0] code_sel;
   assign grant_sel = req_b & (~req_a | rr_b_reg);
   assign code_sel  = grant_sel ? code_b : code_a;

   // State and datapath registers; reset aborts any transaction at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         cnt_reg          <= '0;
         grant_b_reg      <= 1'b0;
         rr_b_reg         <= 1'b0;
         prog_code_reg    <= 3'd0;
         update_clock_reg <= 1'b0;
         ack_a_reg        <= 1'b0;
         ack_b_reg        <= 1'b0;
         ack_err_reg      <= 1'b0;
         busy_reg         <= 1'b0;
         err_reg          <= 1'b0;
`ifdef DCM_PROG_CTRL_RETRY_EN
         retry_reg        <= 1'b0;
`endif
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         grant_b_reg      <= grant_b_next;
         rr_b_reg         <= rr_b_next;
         prog_code_reg    <= prog_code_next;
         update_clock_reg <= update_clock_next;
         ack_a_reg        <= ack_a_next;
         ack_b_reg        <= ack_b_next;
         ack_err_reg      <= ack_err_next;
         busy_reg         <= busy_next;
         err_reg          <= err_next;
`ifdef DCM_PROG_CTRL_RETRY_EN
         retry_reg        <= retry_next;
`endif
      end
   end

   // Next-state logic; outputs are computed for the state being entered so
   // every port comes straight from a flop.
   always_comb begin
      state_next        = state_reg;
      cnt_next          = cnt_reg;
      grant_b_next      = grant_b_reg;
      rr_b_next         = rr_b_reg;
      prog_code_next    = prog_code_reg;
      update_clock_next = 1'b0;
      ack_a_next        = 1'b0;
      ack_b_next        = 1'b0;
      ack_err_next      = 1'b0;
      err_set           = 1'b0;
`ifdef DCM_PROG_CTRL_RETRY_EN
      retry_next        = retry_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (req_a || req_b) begin
               grant_b_next   = grant_sel;
               prog_code_next = code_sel;
               cnt_next       = '0;
`ifdef DCM_PROG_CTRL_RETRY_EN
               retry_next     = 1'b0;
`endif
               if (code_sel == prog_rb) begin
                  // DCM already runs this code: acknowledge without a strobe.
                  state_next = ST_DONE;
                  ack_a_next = ~grant_sel;
                  ack_b_next = grant_sel;
               end else begin
                  state_next        = ST_PULSE;
                  update_clock_next = 1'b1;
               end
            end
         end
         ST_PULSE: begin
            if (cnt_reg == PULSE_LAST) begin
               state_next = ST_SETTLE;
               cnt_next   = '0;
            end else begin
               cnt_next          = cnt_reg + 1'b1;
               update_clock_next = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (cnt_reg == SETTLE_LAST) begin
               state_next = ST_CHECK;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_CHECK: begin
            if (prog_rb == prog_code_reg) begin
               state_next = ST_DONE;
               ack_a_next = ~grant_b_reg;
               ack_b_next = grant_b_reg;
            end else begin
`ifdef DCM_PROG_CTRL_RETRY_EN
               if (!retry_reg) begin
                  retry_next        = 1'b1;
                  state_next        = ST_PULSE;
                  cnt_next          = '0;
                  update_clock_next = 1'b1;
               end else begin
                  state_next   = ST_DONE;
                  ack_a_next   = ~grant_b_reg;
                  ack_b_next   = grant_b_reg;
                  ack_err_next = 1'b1;
                  err_set      = 1'b1;
               end
`else
               state_next   = ST_DONE;
               ack_a_next   = ~grant_b_reg;
               ack_b_next   = grant_b_reg;
               ack_err_next = 1'b1;
               err_set      = 1'b1;
`endif
            end
         end
         ST_DONE: begin
            rr_b_next  = ~grant_b_reg;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      busy_next = (state_next != ST_IDLE);
      // A failure in the same cycle as a clear keeps the flag set.
      err_next  = err_set ? 1'b1 : (clr_err ? 1'b0 : err_reg);
   end

   assign prog_code    = prog_code_reg;
   assign update_clock = update_clock_reg;
   assign ack_a        = ack_a_reg;
   assign ack_b        = ack_b_reg;
   assign ack_err      = ack_err_reg;
   assign busy         = busy_reg;
   assign err          = err_reg;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Testbench for dcm_prog_ctrl: DCM behavioural model plus per-scenario tasks.
module tb_dcm_prog_ctrl;
   localparam int P = 4;
   localparam int S = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_a = 1'b0;
   logic [2:0] code_a = 3'd0;
   logic       req_b = 1'b0;
   logic [2:0] code_b = 3'd0;
   logic       clr_err = 1'b0;
   logic [2:0] prog_rb = 3'd0;
   logic [2:0] prog_code;
   logic       update_clock, ack_a, ack_b, ack_err, busy, err;

   // DCM model controls: force holds readback at rb_val (stuck DCM).
   logic       rb_force = 1'b0;
   logic [2:0] rb_val = 3'd0;

   int checks = 0;
   int errors = 0;

   // Reference-model state
   logic [2:0] exp_rb = 3'd0;
   bit         model_rr = 1'b0;   // 1 = B favoured on a tie

   dcm_prog_ctrl #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
      .clock(clock), .reset(reset),
      .req_a(req_a), .code_a(code_a), .req_b(req_b), .code_b(code_b),
      .clr_err(clr_err), .prog_rb(prog_rb),
      .prog_code(prog_code), .update_clock(update_clock),
      .ack_a(ack_a), .ack_b(ack_b), .ack_err(ack_err), .busy(busy), .err(err)
   );

   always #5 clock = ~clock;

   // DCM: adopts the presented code while strobed, unless stuck.
   always @(posedge clock) begin
      if (rb_force) prog_rb <= rb_val;
      else if (update_clock) prog_rb <= prog_code;
   end

   function automatic int exp_lat(logic [2:0] code, logic [2:0] rb, bit follow);
      if (code == rb) return 1;
      if (follow) return P + S + 2;
`ifdef DCM_PROG_CTRL_RETRY_EN
      return 2 * (P + S) + 3;
`else
      return P + S + 2;
`endif
   endfunction

   function automatic int exp_strobes(logic [2:0] code, logic [2:0] rb, bit follow);
      if (code == rb) return 0;
      if (follow) return P;
`ifdef DCM_PROG_CTRL_RETRY_EN
      return 2 * P;
`else
      return P;
`endif
   endfunction

   // Drives one request set in an IDLE cycle and measures the transaction.
   task automatic do_txn(input bit a, input logic [2:0] ca, input bit b, input logic [2:0] cb,
                         output int lat, output bit ga, output bit gb, output bit aerr,
                         output int strobes, output int first_strobe, output int busy_cyc,
                         output logic [2:0] code_ack, output bit err_ack, output bit tmo);
      lat = 0; ga = 0; gb = 0; aerr = 0; strobes = 0; first_strobe = 0;
      busy_cyc = 0; code_ack = 3'd0; err_ack = 0; tmo = 1;
      @(negedge clock);
      req_a = a; code_a = ca; req_b = b; code_b = cb;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clock);
         if (update_clock) begin
            strobes++;
            if (first_strobe == 0) first_strobe = k;
         end
         if (busy) busy_cyc++;
         if (ack_a || ack_b) begin
            lat = k; ga = ack_a; gb = ack_b; aerr = ack_err;
            code_ack = prog_code; err_ack = err; tmo = 0;
            if (ack_a) req_a = 1'b0;
            if (ack_b) req_b = 1'b0;
            break;
         end
      end
      $display("txn req_a=%0d code_a=%0d req_b=%0d code_b=%0d -> ack_a=%0d ack_b=%0d lat=%0d ack_err=%0d strobes=%0d code=%0d",
               a, ca, b, cb, ga, gb, lat, aerr, strobes, code_ack);
   endtask

   task automatic set_rb(input logic [2:0] v);
      @(negedge clock);
      rb_force = 1'b1; rb_val = v;
      @(negedge clock);
      rb_force = 1'b0;
      exp_rb = v;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_rr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if ({prog_code, update_clock, ack_a, ack_b, ack_err, busy, err} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%b want=0", {prog_code, update_clock, ack_a, ack_b, ack_err, busy, err});
      end
      reset = 1'b0;
      model_rr = 1'b0;
   endtask

   task automatic test_single();
      int lat, st, fs, bc; bit ga, gb, ae, ea, tmo; logic [2:0] ck;
      set_rb(3'd0);
      do_txn(1, 3'd3, 0, 3'd0, lat, ga, gb, ae, st, fs, bc, ck, ea, tmo);
      checks++; if (tmo || lat != exp_lat(3'd3, exp_rb, 1)) begin errors++; $display("FAIL single_latency got=%0d want=%0d", lat, exp_lat(3'd3, exp_rb, 1)); end
      checks++; if (ga !== 1'b1 || gb !== 1'b0) begin errors++; $display("FAIL single_ack got a=%0d b=%0d want a=1 b=0", ga, gb); end
      checks++; if (st != P || fs != 1) begin errors++; $display("FAIL single_strobe got n=%0d first=%0d want n=%0d first=1", st, fs, P); end
      checks++; if (ck !== 3'd3) begin errors++; $display("FAIL single_code got=%0d want=3", ck); end
      checks++; if (ae !== 1'b0 || ea !== 1'b0) begin errors++; $display("FAIL single_err got ack_err=%0d err=%0d want 0 0", ae, ea); end
      exp_rb = 3'd3;
      model_rr = 1'b1;
   endtask

   task automatic test_both();
      int lat, st, fs, bc; bit ga, gb, ae, ea, tmo; logic [2:0] ck;
      apply_reset();
      do_txn(1, 3'd2, 1, 3'd5, lat, ga, gb, ae, st, fs, bc, ck, ea, tmo);
      checks++; if (tmo || ga !== 1'b1 || gb !== 1'b0) begin errors++; $display("FAIL both_first_winner got a=%0d b=%0d want a=1", ga, gb); end
      checks++; if (lat != exp_lat(3'd2, exp_rb, 1) || ck !== 3'd2) begin errors++; $display("FAIL both_first got lat=%0d code=%0d want lat=%0d code=2", lat, ck, exp_lat(3'd2, exp_rb, 1)); end
      exp_rb = 3'd2;
      do_txn(0, 3'd0, 1, 3'd5, lat, ga, gb, ae, st, fs, bc, ck, ea, tmo);
      checks++; if (tmo || gb !== 1'b1 || ga !== 1'b0) begin errors++; $display("FAIL both_second_winner got a=%0d b=%0d want b=1", ga, gb); end
      checks++; if (lat != P + S + 2 || ck !== 3'd5) begin errors++; $display("FAIL both_second got lat=%0d code=%0d want lat=%0d code=5", lat, ck, P + S + 2); end
      exp_rb = 3'd5;
      model_rr = 1'b0;
   endtask

   task automatic test_noop();
      int lat, st, fs, bc; bit ga, gb, ae, ea, tmo; logic [2:0] ck;
      set_rb(3'd4);
      do_txn(0, 3'd0, 1, 3'd4, lat, ga, gb, ae, st, fs, bc, ck, ea, tmo);
      checks++; if (tmo || lat != 1 || gb !== 1'b1) begin errors++; $display("FAIL noop_ack got lat=%0d b=%0d want lat=1 b=1", lat, gb); end
      checks++; if (st != 0) begin errors++; $display("FAIL noop_strobe got=%0d want=0", st); end
      checks++; if (bc != 1) begin errors++; $display("FAIL noop_busy_cycles got=%0d want=1", bc); end
      @(negedge clock);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop_busy_after got=%0d want=0", busy); end
      model_rr = 1'b0;
   endtask

   task automatic test_verify_fail();
      int lat, st, fs, bc; bit ga, gb, ae, ea, tmo; logic [2:0] ck;
      @(negedge clock);
      rb_force = 1'b1; rb_val = 3'd1; exp_rb = 3'd1;
      @(negedge clock);
      do_txn(1, 3'd6, 0, 3'd0, lat, ga, gb, ae, st, fs, bc, ck, ea, tmo);
      checks++; if (tmo || lat != exp_lat(3'd6, exp_rb, 0) || ga !== 1'b1) begin errors++; $display("FAIL fail_latency got=%0d want=%0d", lat, exp_lat(3'd6, exp_rb, 0)); end
      checks++; if (ae !== 1'b1 || ea !== 1'b1) begin errors++; $display("FAIL fail_flags got ack_err=%0d err=%0d want 1 1", ae, ea); end
      checks++; if (st != exp_strobes(3'd6, exp_rb, 0)) begin errors++; $display("FAIL fail_strobes got=%0d want=%0d", st, exp_strobes(3'd6, exp_rb, 0)); end
      repeat (3) @(negedge clock);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0d want=1", err); end
      clr_err = 1'b1;
      @(negedge clock);
      clr_err = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%0d want=0", err); end
      model_rr = 1'b1;
      // clear held across a new failure: the failure must still register
      clr_err = 1'b1;
      do_txn(1, 3'd6, 0, 3'd0, lat, ga, gb, ae, st, fs, bc, ck, ea, tmo);
      checks++; if (tmo || ea !== 1'b1 || ae !== 1'b1) begin errors++; $display("FAIL err_set_wins got err=%0d ack_err=%0d want 1 1", ea, ae); end
      @(negedge clock);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_after got=%0d want=0", err); end
      clr_err = 1'b0;
      rb_force = 1'b0;
      model_rr = 1'b1;
   endtask

   task automatic test_reset_mid();
      int lat, st, fs, bc; bit ga, gb, ae, ea, tmo; logic [2:0] ck;
      logic [2:0] c;
      bit seen_ack;
      c = exp_rb ^ 3'd2;
      @(negedge clock);
      req_a = 1'b1; code_a = c;
      repeat (8) @(negedge clock);
      checks++; if (busy !== 1'b1 || update_clock !== 1'b0) begin errors++; $display("FAIL mid_settle got busy=%0d strobe=%0d want 1 0", busy, update_clock); end
      #1 reset = 1'b1;
      #1;
      checks++; if ({prog_code, update_clock, ack_a, ack_b, ack_err, busy, err} !== 9'd0) begin errors++; $display("FAIL mid_reset_outputs got=%b want=0", {prog_code, update_clock, ack_a, ack_b, ack_err, busy, err}); end
      req_a = 1'b0;
      seen_ack = 0;
      repeat (3) begin
         @(negedge clock);
         if (ack_a || ack_b || busy) seen_ack = 1;
      end
      reset = 1'b0;
      repeat (2) begin
         @(negedge clock);
         if (ack_a || ack_b || busy) seen_ack = 1;
      end
      checks++; if (seen_ack) begin errors++; $display("FAIL mid_no_ack got activity=1 want=0"); end
      exp_rb = c;
      model_rr = 1'b0;
      do_txn(1, c ^ 3'd5, 0, 3'd0, lat, ga, gb, ae, st, fs, bc, ck, ea, tmo);
      checks++; if (tmo || lat != P + S + 2 || ga !== 1'b1 || ae !== 1'b0 || ck !== (c ^ 3'd5)) begin errors++; $display("FAIL mid_fresh got lat=%0d a=%0d ack_err=%0d code=%0d want lat=%0d a=1 ack_err=0 code=%0d", lat, ga, ae, ck, P + S + 2, c ^ 3'd5); end
      exp_rb = c ^ 3'd5;
      model_rr = 1'b1;
   endtask

   task automatic test_back_to_back();
      int lat, st, fs, bc; bit ga, gb, ae, ea, tmo; logic [2:0] ck;
      logic [2:0] ca, cb, wcode;
      bit b, b_pend, win_b;
      int a_wait, b_wait;
      b_pend = 0; a_wait = 0; b_wait = 0;
      for (int i = 0; i < 10; i++) begin
         ca = 3'($urandom_range(0, 7));
         cb = 3'($urandom_range(0, 7));
         b  = b_pend | ($urandom_range(0, 1) == 1);
         win_b = b && model_rr;
         wcode = win_b ? cb : ca;
         do_txn(1, ca, b, cb, lat, ga, gb, ae, st, fs, bc, ck, ea, tmo);
         checks++; if (tmo || ga !== !win_b || gb !== win_b) begin errors++; $display("FAIL rr_winner iter=%0d got a=%0d b=%0d want b=%0d", i, ga, gb, win_b); end
         checks++; if (lat != exp_lat(wcode, exp_rb, 1) || ck !== wcode || ae !== 1'b0) begin errors++; $display("FAIL rr_txn iter=%0d got lat=%0d code=%0d ack_err=%0d want lat=%0d code=%0d ack_err=0", i, lat, ck, ae, exp_lat(wcode, exp_rb, 1), wcode); end
         if (win_b) begin a_wait++; b_wait = 0; end
         else begin a_wait = 0; b_wait = b ? b_wait + 1 : 0; end
         checks++; if (a_wait > 1 || b_wait > 1) begin errors++; $display("FAIL rr_starve iter=%0d got a_wait=%0d b_wait=%0d want <=1", i, a_wait, b_wait); end
         exp_rb = wcode;
         model_rr = !win_b;
         b_pend = b && !win_b;
      end
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_both();
      test_noop();
      test_verify_fail();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
